// File: rtl/afs_abort_xlate.sv
// Translates an AFS/RX abort code into a local error code.
// Zero and (optionally) small negative errno values resolve immediately.
// Any other code is looked up by a linear search of an in-memory table,
// read one 64-bit entry at a time over a fixed-latency Avalon-MM master.
//
// Call/return handshake: a call is taken when start=1 and the block is
// idle (busy=0). The result is offered with done=1 and held, together
// with returndata and hit, until a cycle in which stall=0. That cycle
// completes the return. No new call is taken in that cycle.
module afs_abort_xlate #(
    parameter int ENTRIES_MAX = 64,
    parameter int RD_LAT      = 2,
    parameter int PASS_NEG    = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        stall,
    output logic [31:0] returndata,
    output logic        hit,
    input  logic [31:0] abort_code,
    input  logic [63:0] table_base,
    input  logic [15:0] table_len,
    input  logic [31:0] default_err,
    output logic [63:0] avmm_0_rw_address,
    output logic [7:0]  avmm_0_rw_byteenable,
    output logic        avmm_0_rw_read,
    input  logic [63:0] avmm_0_rw_readdata,
    output logic        avmm_0_rw_write,
    output logic [63:0] avmm_0_rw_writedata,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CMP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] EMAX      = 16'(ENTRIES_MAX);
    localparam logic [3:0]  WAIT_LAST = 4'(RD_LAT - 1);
    // Smallest code treated as a negative errno: -4095.
    localparam logic [31:0] NEG_MIN   = 32'hFFFF_F001;

    state_t      state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [63:0] base_q, base_d;
    logic [15:0] n_q, n_d;
    logic [31:0] derr_q, derr_d;
    logic [15:0] idx_q, idx_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic [31:0] result_q, result_d;
    logic        hit_q, hit_d;

    logic        code_is_neg;
    logic        last_entry;

    assign code_is_neg = code_q[31] && (code_q >= NEG_MIN);
    assign last_entry  = ({1'b0, idx_q} + 17'd1) == {1'b0, n_q};

    // State and datapath registers; reset returns everything to idle/zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            base_q   <= '0;
            n_q      <= '0;
            derr_q   <= '0;
            idx_q    <= '0;
            wcnt_q   <= '0;
            rdata_q  <= '0;
            result_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            base_q   <= base_d;
            n_q      <= n_d;
            derr_q   <= derr_d;
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            rdata_q  <= rdata_d;
            result_q <= result_d;
            hit_q    <= hit_d;
        end
    end

    // Next-state and datapath updates for the call/search sequence.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        base_d   = base_q;
        n_d      = n_q;
        derr_d   = derr_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        rdata_d  = rdata_q;
        result_d = result_q;
        hit_d    = hit_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    code_d  = abort_code;
                    base_d  = table_base;
                    n_d     = (table_len < EMAX) ? table_len : EMAX;
                    derr_d  = default_err;
                    hit_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                hit_d = 1'b0;
                if (code_q == 32'd0) begin
                    result_d = 32'd0;
                    state_d  = ST_DONE;
                end else if ((PASS_NEG != 0) && code_is_neg) begin
                    result_d = code_q;
                    state_d  = ST_DONE;
                end else if (n_q == 16'd0) begin
                    result_d = derr_q;
                    state_d  = ST_DONE;
                end else begin
                    idx_d   = 16'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wcnt_d  = 4'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid exactly RD_LAT cycles after the strobe.
                if (wcnt_q == WAIT_LAST) begin
                    rdata_d = avmm_0_rw_readdata;
                    state_d = ST_CMP;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            ST_CMP: begin
                if (rdata_q[63:32] == code_q) begin
                    result_d = rdata_q[31:0];
                    hit_d    = 1'b1;
                    state_d  = ST_DONE;
                end else if (last_entry) begin
                    result_d = derr_q;
                    hit_d    = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                if (!stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from state so reset clears them without a clock.
    assign busy                 = (state_q != ST_IDLE);
    assign done                 = (state_q == ST_DONE);
    assign returndata           = done ? result_q : 32'd0;
    assign hit                  = done & hit_q;
    assign avmm_0_rw_read       = (state_q == ST_REQ);
    assign avmm_0_rw_address    = avmm_0_rw_read ? (base_q + {45'd0, idx_q, 3'd0}) : 64'd0;
    assign avmm_0_rw_byteenable = avmm_0_rw_read ? 8'hFF : 8'h00;
    assign avmm_0_rw_write      = 1'b0;
    assign avmm_0_rw_writedata  = 64'd0;
    assign state_dbg            = state_q;

endmodule

// File: tb/tb_afs_abort_xlate.sv
// Directed bench for afs_abort_xlate: two instances (default parameters,
// and PASS_NEG=0 with RD_LAT=1) against a fixed-latency memory model.
module tb_afs_abort_xlate;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam logic [31:0] DERR = 32'hFFFF_FF87;
    localparam logic [63:0] GARB = 64'hBAD0_BAD0_BAD0_BAD0;

    // clock / reset
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    // shared inputs
    logic        start0 = 1'b0, start1 = 1'b0, stall = 1'b0;
    logic [31:0] abort_code = '0, default_err = '0;
    logic [63:0] table_base = '0;
    logic [15:0] table_len = '0;

    // dut0 outputs
    logic        busy0, done0, hit0, rd0, wr0;
    logic [31:0] ret0;
    logic [63:0] addr0, wdata0, rdata0;
    logic [7:0]  be0;
    logic [2:0]  st0;
    // dut1 outputs
    logic        busy1, done1, hit1, rd1, wr1;
    logic [31:0] ret1;
    logic [63:0] addr1, wdata1, rdata1;
    logic [7:0]  be1;
    logic [2:0]  st1;

    afs_abort_xlate #(.ENTRIES_MAX(64), .RD_LAT(LAT0), .PASS_NEG(1)) dut0 (
        .clock(clock), .resetn(resetn), .start(start0), .busy(busy0), .done(done0),
        .stall(stall), .returndata(ret0), .hit(hit0), .abort_code(abort_code),
        .table_base(table_base), .table_len(table_len), .default_err(default_err),
        .avmm_0_rw_address(addr0), .avmm_0_rw_byteenable(be0), .avmm_0_rw_read(rd0),
        .avmm_0_rw_readdata(rdata0), .avmm_0_rw_write(wr0), .avmm_0_rw_writedata(wdata0),
        .state_dbg(st0)
    );

    afs_abort_xlate #(.ENTRIES_MAX(64), .RD_LAT(LAT1), .PASS_NEG(0)) dut1 (
        .clock(clock), .resetn(resetn), .start(start1), .busy(busy1), .done(done1),
        .stall(stall), .returndata(ret1), .hit(hit1), .abort_code(abort_code),
        .table_base(table_base), .table_len(table_len), .default_err(default_err),
        .avmm_0_rw_address(addr1), .avmm_0_rw_byteenable(be1), .avmm_0_rw_read(rd1),
        .avmm_0_rw_readdata(rdata1), .avmm_0_rw_write(wr1), .avmm_0_rw_writedata(wdata1),
        .state_dbg(st1)
    );

    // selected-instance view
    logic        sel = 1'b0;
    logic        m_done, m_hit;
    logic [31:0] m_ret;
    assign m_done = sel ? done1 : done0;
    assign m_hit  = sel ? hit1  : hit0;
    assign m_ret  = sel ? ret1  : ret0;

    // memory model: table image plus fixed-latency read pipes
    logic [63:0] tbl [0:511];
    logic [63:0] cur_base = '0;
    logic [63:0] pipe0 [0:LAT0-1];
    logic [63:0] pipe1 [0:LAT1-1];
    assign rdata0 = pipe0[LAT0-1];
    assign rdata1 = pipe1[LAT1-1];

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        logic [63:0] off;
        off = (a - cur_base) >> 3;
        if (off < 64'd512) return tbl[off[8:0]];
        return GARB;
    endfunction

    always @(posedge clock) begin
        for (int i = LAT0 - 1; i > 0; i--) pipe0[i] <= pipe0[i-1];
        pipe0[0] <= rd0 ? mem_rd(addr0) : GARB;
        for (int i = LAT1 - 1; i > 0; i--) pipe1[i] <= pipe1[i-1];
        pipe1[0] <= rd1 ? mem_rd(addr1) : GARB;
    end

    // read monitor (sampled away from the active edge)
    int          reads = 0;
    int          writes = 0;
    logic [63:0] obs_addr [0:127];
    logic [7:0]  obs_be   [0:127];
    always @(negedge clock) begin
        if (rd0 || rd1) begin
            obs_addr[reads % 128] <= rd0 ? addr0 : addr1;
            obs_be[reads % 128]   <= rd0 ? be0 : be1;
            reads <= reads + 1;
        end
        if (wr0 || wr1 || (wdata0 != 64'd0) || (wdata1 != 64'd0)) writes <= writes + 1;
    end

    // scoreboard
    int          checks = 0;
    int          errors = 0;
    int          r0 = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reads();
        int n;
        n = reads - r0;
        check("rd_count", 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) break;
            check("rd_addr", obs_addr[(r0 + i) % 128], exp_q.pop_front());
            check("rd_be", 64'(obs_be[(r0 + i) % 128]), 64'hFF);
        end
        exp_q.delete();
    endtask

    // driver: issue one call at a negedge with the instance idle; returns
    // at the first negedge that shows done, with lat counted in cycles
    task automatic do_call(input logic which, input logic [31:0] code, input logic [63:0] base,
                           input logic [15:0] len, output int lat,
                           output logic [31:0] rd, output logic h);
        sel        = which;
        cur_base   = base;
        r0         = reads;
        abort_code = code;
        table_base = base;
        table_len  = len;
        default_err = DERR;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        start1 = 1'b0;
        abort_code  = ~code;
        table_base  = base ^ 64'h8000;
        table_len   = 16'hFFFF;
        default_err = 32'h1234_5678;
        lat = 1;
        while (!m_done && lat < 3000) begin
            @(negedge clock);
            lat++;
        end
        if (!m_done) check("timeout", 64'd0, 64'd1);
        rd = m_ret;
        h  = m_hit;
    endtask

    int          lat;
    logic [31:0] rv;
    logic        hv;

    initial begin
        for (int i = 0; i < 512; i++) tbl[i] = {32'h1000_0000 + 32'(i), 32'h0000_0100 + 32'(i)};
        tbl[1] = {32'hFFFF_FFFE, 32'h0000_0042};
        tbl[5] = {32'h1000_0003, 32'h0000_AAAA};
        for (int i = 0; i < LAT0; i++) pipe0[i] = GARB;
        for (int i = 0; i < LAT1; i++) pipe1[i] = GARB;

        // reset values
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_hit", 64'(hit0), 64'd0);
        check("rst_ret", 64'(ret0), 64'd0);
        check("rst_read", 64'(rd0), 64'd0);
        check("rst_addr", addr0, 64'd0);
        check("rst_be", 64'(be0), 64'd0);
        check("rst_state", 64'(st0), 64'd0);
        resetn = 1'b1;
        @(negedge clock);

        // zero code resolves in CHECK
        do_call(1'b0, 32'd0, 64'h1000, 16'd4, lat, rv, hv);
        check("zero_lat", 64'(lat), 64'd2);
        check("zero_ret", 64'(rv), 64'd0);
        check("zero_hit", 64'(hv), 64'd0);
        check_reads();
        @(negedge clock);

        // negative errno passthrough (-2, -4095)
        do_call(1'b0, 32'hFFFF_FFFE, 64'h1000, 16'd4, lat, rv, hv);
        check("neg2_lat", 64'(lat), 64'd2);
        check("neg2_ret", 64'(rv), 64'hFFFF_FFFE);
        check("neg2_hit", 64'(hv), 64'd0);
        check_reads();
        @(negedge clock);
        do_call(1'b0, 32'hFFFF_F001, 64'h1000, 16'd4, lat, rv, hv);
        check("neg4095_lat", 64'(lat), 64'd2);
        check("neg4095_ret", 64'(rv), 64'hFFFF_F001);
        check_reads();
        @(negedge clock);

        // -4096 is outside the errno range: searched, misses 4 entries
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h1000 + 64'(i * 8));
        do_call(1'b0, 32'hFFFF_F000, 64'h1000, 16'd4, lat, rv, hv);
        check("neg4096_lat", 64'(lat), 64'd18);
        check("neg4096_ret", 64'(rv), 64'(DERR));
        check("neg4096_hit", 64'(hv), 64'd0);
        check_reads();
        @(negedge clock);

        // match at index 2
        exp_q = '{64'h1000, 64'h1008, 64'h1010};
        do_call(1'b0, 32'h1000_0002, 64'h1000, 16'd4, lat, rv, hv);
        check("m2_lat", 64'(lat), 64'd14);
        check("m2_ret", 64'(rv), 64'h102);
        check("m2_hit", 64'(hv), 64'd1);
        check_reads();
        @(negedge clock);

        // length clipped to ENTRIES_MAX, no match
        for (int i = 0; i < 64; i++) exp_q.push_back(64'h4000 + 64'(i * 8));
        do_call(1'b0, 32'h5555_5555, 64'h4000, 16'd300, lat, rv, hv);
        check("clip_lat", 64'(lat), 64'd258);
        check("clip_ret", 64'(rv), 64'(DERR));
        check("clip_hit", 64'(hv), 64'd0);
        check_reads();
        @(negedge clock);

        // empty table
        do_call(1'b0, 32'h1000_0000, 64'h1000, 16'd0, lat, rv, hv);
        check("empty_lat", 64'(lat), 64'd2);
        check("empty_ret", 64'(rv), 64'(DERR));
        check_reads();
        @(negedge clock);

        // duplicate code at indices 3 and 5: first one wins
        for (int i = 0; i < 4; i++) exp_q.push_back(64'h1000 + 64'(i * 8));
        do_call(1'b0, 32'h1000_0003, 64'h1000, 16'd8, lat, rv, hv);
        check("dup_lat", 64'(lat), 64'd18);
        check("dup_ret", 64'(rv), 64'h103);
        check("dup_hit", 64'(hv), 64'd1);
        check_reads();
        @(negedge clock);

        // address wraps past 2^64
        exp_q = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8};
        do_call(1'b0, 32'h1000_0003, 64'hFFFF_FFFF_FFFF_FFF0, 16'd4, lat, rv, hv);
        check("wrap_lat", 64'(lat), 64'd18);
        check("wrap_ret", 64'(rv), 64'h103);
        check_reads();
        @(negedge clock);

        // PASS_NEG=0, RD_LAT=1: -2 is searched and found at index 1
        exp_q = '{64'h2000, 64'h2008};
        do_call(1'b1, 32'hFFFF_FFFE, 64'h2000, 16'd4, lat, rv, hv);
        check("np_lat", 64'(lat), 64'd8);
        check("np_ret", 64'(rv), 64'h42);
        check("np_hit", 64'(hv), 64'd1);
        check_reads();
        @(negedge clock);

        // consumer stall holds the result; start while busy is ignored
        stall = 1'b1;
        exp_q = '{64'h1000};
        do_call(1'b0, 32'h1000_0000, 64'h1000, 16'd4, lat, rv, hv);
        check("stall_lat", 64'(lat), 64'd6);
        check("stall_ret", 64'(rv), 64'h100);
        check_reads();
        start0 = 1'b1;
        abort_code = 32'h1000_0002;
        table_base = 64'h1000;
        table_len  = 16'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_done", 64'(done0), 64'd1);
            check("stall_hold", 64'(ret0), 64'h100);
            check("stall_hit", 64'(hit0), 64'd1);
        end
        stall = 1'b0;
        @(negedge clock);
        check("release_idle", 64'(busy0), 64'd0);
        start0 = 1'b0;
        @(negedge clock);
        check("release_no_call", 64'(busy0), 64'd0);

        // reset pulsed in WAIT
        sel = 1'b0;
        cur_base = 64'h1000;
        r0 = reads;
        exp_q = '{64'h1000};
        abort_code = 32'h1000_0002;
        table_base = 64'h1000;
        table_len  = 16'd4;
        default_err = DERR;
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        repeat (2) @(negedge clock);
        check("pre_rst_wait", 64'(st0), 64'd3);
        #2 resetn = 1'b0;
        #1;
        check("arst_read", 64'(rd0), 64'd0);
        check("arst_busy", 64'(busy0), 64'd0);
        check("arst_state", 64'(st0), 64'd0);
        check("arst_addr", addr0, 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        check_reads();
        @(negedge clock);
        check("post_rst_idle", 64'(busy0), 64'd0);

        exp_q = '{64'h1000, 64'h1008, 64'h1010};
        do_call(1'b0, 32'h1000_0002, 64'h1000, 16'd4, lat, rv, hv);
        check("after_rst_lat", 64'(lat), 64'd14);
        check("after_rst_ret", 64'(rv), 64'h102);
        check("after_rst_hit", 64'(hv), 64'd1);
        check_reads();
        @(negedge clock);

        check("no_writes", 64'(writes), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
